// File: rtl/re_order_buffer.sv
// re_order_buffer: circular in-order retirement buffer with writeback, mispredict flush and operand lookup
module re_order_buffer #(
  parameter int DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH = 5,
  parameter int PC_WIDTH = 32,
  localparam int TAG_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [RD_WIDTH-1:0]   alloc_rd,
  input  logic                  alloc_reg_write,
  input  logic [PC_WIDTH-1:0]   alloc_pc,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  wb_valid,
  input  logic [TAG_WIDTH-1:0]  wb_tag,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_mispredict,
  input  logic [PC_WIDTH-1:0]   wb_target,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic [RD_WIDTH-1:0]   commit_rd,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic                  commit_reg_write,
  output logic [PC_WIDTH-1:0]   commit_pc,
  output logic                  flush_valid,
  output logic [PC_WIDTH-1:0]   flush_pc,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  output logic [TAG_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty
);
  localparam logic [TAG_WIDTH-1:0] ONE = 1;
  localparam logic [TAG_WIDTH:0] FULL_CNT = (TAG_WIDTH+1)'(DEPTH);
  logic                  busy [DEPTH];
  logic                  done [DEPTH];
  logic                  mis [DEPTH];
  logic [RD_WIDTH-1:0]   ent_rd [DEPTH];
  logic                  ent_rw [DEPTH];
  logic [PC_WIDTH-1:0]   ent_pc [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [PC_WIDTH-1:0]   ent_target [DEPTH];
  logic [TAG_WIDTH-1:0]  head, tail;
  logic                  fire, alloc_fire, wb_ok;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign commit_valid = busy[head] && done[head];
  assign fire = commit_valid && commit_ready;
  assign flush_valid = fire && mis[head];
  assign flush_pc = ent_target[head];
  // A resolved mispredict at the head blocks allocation so nothing lands in the slot the flush is about to wipe
  assign alloc_ready = !full && !(busy[head] && done[head] && mis[head]);
  assign alloc_fire = alloc_valid && alloc_ready;
  assign alloc_tag = tail;
  assign wb_ok = wb_valid && busy[wb_tag] && !done[wb_tag] && !flush_valid;
  assign commit_rd = ent_rd[head];
  assign commit_data = ent_data[head];
  assign commit_reg_write = ent_rw[head];
  assign commit_pc = ent_pc[head];
  assign lookup_hit = busy[lookup_tag] && done[lookup_tag];
  assign lookup_data = lookup_hit ? ent_data[lookup_tag] : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
        mis[i] <= 1'b0;
      end
    end else if (flush_valid) begin
      head <= head + ONE;
      tail <= head + ONE;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
        mis[i] <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        mis[tail] <= 1'b0;
        ent_rd[tail] <= alloc_rd;
        ent_rw[tail] <= alloc_reg_write;
        ent_pc[tail] <= alloc_pc;
        tail <= tail + ONE;
      end
      if (wb_ok) begin
        done[wb_tag] <= 1'b1;
        mis[wb_tag] <= wb_mispredict;
        ent_data[wb_tag] <= wb_data;
        ent_target[wb_tag] <= wb_target;
      end
      if (fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        mis[head] <= 1'b0;
        head <= head + ONE;
      end
      count <= count + (TAG_WIDTH+1)'(alloc_fire) - (TAG_WIDTH+1)'(fire);
    end
  end
endmodule

// File: doc/re_order_buffer.md
RE_ORDER_BUFFER -- requirements
Module: re_order_buffer

Interface
REQ-001 Parameter DEPTH, default 16: entry count; SHALL be a power of two and at least 2.
REQ-002 Parameter DATA_WIDTH, default 32: result width.
REQ-003 Parameter RD_WIDTH, default 5: destination register index width.
REQ-004 Parameter PC_WIDTH, default 32: PC and target width. TAG_WIDTH = $clog2(DEPTH) (derived).
REQ-005 clk  in  1  rising-edge clock; single clock domain.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 alloc_valid  in  1  request to allocate the tail entry.
REQ-008 alloc_ready  out  1  tail entry may be allocated this cycle.
REQ-009 alloc_rd / alloc_reg_write / alloc_pc  in  RD_WIDTH / 1 / PC_WIDTH  destination, write-enable, PC of the allocating instruction.
REQ-010 alloc_tag  out  TAG_WIDTH  current tail index; the tag given to this cycle's allocation.
REQ-011 wb_valid / wb_tag / wb_data  in  1 / TAG_WIDTH / DATA_WIDTH  execution result for entry wb_tag.
REQ-012 wb_mispredict / wb_target  in  1 / PC_WIDTH  entry resolved as mispredicted; correct PC.
REQ-013 commit_valid  out  1  head entry is ready to retire.
REQ-014 commit_ready  in  1  the register file accepts the retirement.
REQ-015 commit_rd / commit_data / commit_reg_write / commit_pc  out  RD_WIDTH / DATA_WIDTH / 1 / PC_WIDTH  fields of the head entry.
REQ-016 flush_valid / flush_pc  out  1 / PC_WIDTH  redirect fetch and squash all younger work.
REQ-017 lookup_tag  in  TAG_WIDTH; lookup_hit  out  1; lookup_data  out  DATA_WIDTH  operand-forwarding read port.
REQ-018 count  out  TAG_WIDTH+1; full  out  1; empty  out  1  occupancy status.

Function
REQ-019 Each entry SHALL hold the fields busy, done, mispredict, rd, reg_write, pc, data and target; head, tail and count SHALL be registers.
REQ-020 alloc_ready SHALL be computed as !full && !(head busy && done && mispredict); it SHALL NOT depend on commit_ready (no same-cycle bypass when full).
REQ-021 On alloc_valid && alloc_ready, the tail entry SHALL be written with busy=1, done=0, mispredict=0 and the alloc fields, and tail SHALL become (tail+1) mod DEPTH.
REQ-022 wb_valid to an entry with busy=1 and done=0 SHALL set done=1 and store wb_data, wb_mispredict and wb_target.
REQ-023 wb_valid to an entry that is not busy or already done SHALL be ignored, with no state change.
REQ-024 commit_valid SHALL equal the registered busy && done of the head entry, so a result written back in cycle t is committable no earlier than cycle t+1.
REQ-025 Minimum latency: alloc at t, writeback at t+1, commit_valid at t+2.
REQ-026 Commit fires on commit_valid && commit_ready. On commit, the head entry SHALL be cleared and head SHALL become (head+1) mod DEPTH.
REQ-027 flush_valid SHALL equal commit_valid && commit_ready && head.mispredict (combinational); flush_pc SHALL equal head.target.
REQ-028 On a flush edge, every entry SHALL be cleared, tail SHALL be set to head+1, head SHALL be set to head+1, and count SHALL be set to 0.
REQ-029 A writeback arriving in the flush cycle SHALL be discarded.
REQ-030 A commit of a mispredicting entry SHALL still present commit_reg_write and commit_data as stored, so the branch link write retires.
REQ-031 count SHALL be updated as follows: +1 on allocation only; -1 on commit only; unchanged on simultaneous allocation and commit; range 0..DEPTH.
REQ-032 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-033 Head and tail SHALL wrap modulo DEPTH with no bubble.
REQ-034 lookup_hit SHALL equal busy && done of entry lookup_tag; lookup_data SHALL equal that entry's data, or 0 when lookup_hit is 0.
REQ-035 When the entry under lookup is written back in the same cycle, the lookup SHALL report the registered (old) state.
REQ-036 Any wb_tag or lookup_tag value SHALL be legal input; handling follows REQ-023 and REQ-034.

Reset
REQ-037 While rst=0 at a clock edge: head=tail=count=0 and every busy/done/mispredict bit is cleared, with entries held mid-operation discarded and not retired.
REQ-038 After reset: alloc_ready=1, alloc_tag=0, commit_valid=0, flush_valid=0, lookup_hit=0, empty=1, full=0, count=0.
REQ-039 Inputs SHALL be ignored while rst=0.

Verification (DEPTH=4)
REQ-040 Fill and drain: 4 allocations with no writeback -> full=1, alloc_ready=0, count=4, tags 0,1,2,3. Writebacks in order 2,0,1,3 -> commits in order 0,1,2,3 with the matching data; empty=1 at the end.
REQ-041 Wrap: with steady-state allocation, writeback and commit running for 10 instructions -> alloc_tag sequence 0,1,2,3,0,1,...; count never exceeds 4; commit_pc order matches allocation order.
REQ-042 Full with commit: at count=4 with head done, assert commit_ready and alloc_valid together -> commit occurs, allocation is refused that cycle, and it succeeds the next cycle with count=4.
REQ-043 Mispredict: allocate tags 0-3, writeback tag1 with mispredict and wb_target=0x40, writeback tag0, commit_ready=1 -> tag0 commits, then tag1 commits with flush_valid=1 and flush_pc=0x40; next cycle count=0, head=tail=2, tags 2 and 3 are never committed.
REQ-044 Stale and late writebacks: writeback to a free tag, and a second writeback to a done tag with different data -> no state change; commit_data equals the first value.
REQ-045 Reset mid-operation: drive rst=0 at count=3 -> next cycle count=0, commit_valid=0, alloc_tag=0, and no commit is emitted.
